// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions used by both the write-side and read-side pointer blocks.
// Holds the default geometry, depth derivation and Gray/binary conversion helpers.
package fifo_pkg;

    localparam int ADDR_SIZE_DEFAULT    = 3;
    localparam int AFULL_THRESH_DEFAULT = 6;

    function automatic int depth_of(input int addr_size);
        return 1 << addr_size;
    endfunction

    // Operands are zero-extended; the leading zeros leave both conversions unchanged.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign bin[gi] = ^gray[W-1:gi];
        end
    endgenerate

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag logic of the async FIFO.
// Flags come from the read pointer after synchronization, so they may overstate fill but never understate it.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE    = ADDR_SIZE_DEFAULT,
    parameter int AFULL_THRESH = AFULL_THRESH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    input  logic                 ovf_clr,
    output logic                 wclken,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 wovf
);

    localparam int PW    = ADDR_SIZE + 1;
    localparam int DEPTH = depth_of(ADDR_SIZE);
    localparam logic [PW-1:0] AFULL_LVL =
        PW'((AFULL_THRESH > DEPTH) ? DEPTH : AFULL_THRESH);

    logic [PW-1:0] wbin_reg;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] level_next;
    logic          full_next;

    gray2bin #(.W(PW)) u_rptr_bin (
        .gray (wq2_rptr),
        .bin  (rbin_sync)
    );

    assign wclken     = wr_en & ~wfull;
    assign waddr      = wbin_reg[ADDR_SIZE-1:0];
    assign wbin_next  = wbin_reg + {{(PW-1){1'b0}}, wclken};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    assign level_next = wbin_next - rbin_sync;

    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted, rest equal.
    assign full_next = (wgray_next == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbin_reg     <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin_reg     <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= full_next;
            wlevel       <= level_next;
            walmost_full <= (level_next >= AFULL_LVL);
            // A dropped write outranks a simultaneous clear so no overflow is ever lost.
            if (wr_en && wfull) begin
                wovf <= 1'b1;
            end else if (ovf_clr) begin
                wovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full at ADDR_SIZE=3, AFULL_THRESH=6.
module tb_fifo_wptr_full;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wq2_rptr;
    logic       ovf_clr;
    logic       wclken;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wlevel;
    logic       wovf;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_wptr_full #(.ADDR_SIZE(3), .AFULL_THRESH(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wq2_rptr     (wq2_rptr),
        .ovf_clr      (ovf_clr),
        .wclken       (wclken),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; wr_en = 1'b1; ovf_clr = 1'b0; wq2_rptr = 4'd0;
        tick(); tick();
        n_cmp++; if (wptr !== 4'd0) begin n_bad++; $display("FAIL reset_wptr got=%0d exp=0", wptr); end
        n_cmp++; if (waddr !== 3'd0) begin n_bad++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
        n_cmp++; if (wlevel !== 4'd0) begin n_bad++; $display("FAIL reset_wlevel got=%0d exp=0", wlevel); end
        n_cmp++; if ({wfull, walmost_full, wovf} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=000", {wfull, walmost_full, wovf});
        end
        $display("reset: wptr=%0d waddr=%0d wlevel=%0d flags=%b", wptr, waddr, wlevel, {wfull, walmost_full, wovf});
    endtask

    task automatic test_fill;
        logic [3:0] exp_ptr [8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
        rst_n = 1'b1; wq2_rptr = 4'd0; wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (waddr !== 3'(i)) begin n_bad++; $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", i, waddr, i); end
            n_cmp++; if (wclken !== 1'b1) begin n_bad++; $display("FAIL fill_wclken[%0d] got=%b exp=1", i, wclken); end
            tick();
            n_cmp++; if (wptr !== exp_ptr[i]) begin n_bad++; $display("FAIL fill_wptr[%0d] got=%0d exp=%0d", i, wptr, exp_ptr[i]); end
            n_cmp++; if (wlevel !== 4'(i + 1)) begin n_bad++; $display("FAIL fill_wlevel[%0d] got=%0d exp=%0d", i, wlevel, i + 1); end
            n_cmp++; if (walmost_full !== (i + 1 >= 6)) begin n_bad++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, walmost_full, (i + 1 >= 6)); end
            n_cmp++; if (wfull !== (i == 7)) begin n_bad++; $display("FAIL fill_wfull[%0d] got=%b exp=%b", i, wfull, (i == 7)); end
            $display("fill write %0d: wptr=%0d wlevel=%0d afull=%b full=%b", i + 1, wptr, wlevel, walmost_full, wfull);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_overflow;
        wr_en = 1'b1; ovf_clr = 1'b0;
        #1;
        n_cmp++; if (wclken !== 1'b0) begin n_bad++; $display("FAIL ovf_wclken got=%b exp=0", wclken); end
        tick();
        wr_en = 1'b0;
        n_cmp++; if (wptr !== 4'd12) begin n_bad++; $display("FAIL ovf_wptr_hold got=%0d exp=12", wptr); end
        n_cmp++; if (wovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b exp=1", wovf); end
        n_cmp++; if (wlevel !== 4'd8 || wfull !== 1'b1) begin n_bad++; $display("FAIL ovf_state got=lvl%0d/full%b exp=lvl8/full1", wlevel, wfull); end
        $display("overflow write: wptr=%0d wovf=%b", wptr, wovf);
        ovf_clr = 1'b1;
        tick();
        n_cmp++; if (wovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%b exp=0", wovf); end
        $display("ovf_clr: wovf=%b", wovf);
        wr_en = 1'b1; ovf_clr = 1'b1;
        tick();
        n_cmp++; if (wovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set_priority got=%b exp=1", wovf); end
        $display("overflow+clr: wovf=%b", wovf);
        wr_en = 1'b0; ovf_clr = 1'b1;
        tick();
        n_cmp++; if (wovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear2 got=%b exp=0", wovf); end
        ovf_clr = 1'b0;
    endtask

    task automatic test_drain;
        logic [3:0] exp_lvl [3] = '{4'd7, 4'd6, 4'd5};
        logic       exp_af  [3] = '{1'b1, 1'b1, 1'b0};
        wr_en = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            wq2_rptr = g(4'(r));
            tick();
            n_cmp++; if (wfull !== 1'b0) begin n_bad++; $display("FAIL drain_wfull[%0d] got=%b exp=0", r, wfull); end
            n_cmp++; if (wlevel !== exp_lvl[r-1]) begin n_bad++; $display("FAIL drain_wlevel[%0d] got=%0d exp=%0d", r, wlevel, exp_lvl[r-1]); end
            n_cmp++; if (walmost_full !== exp_af[r-1]) begin n_bad++; $display("FAIL drain_afull[%0d] got=%b exp=%b", r, walmost_full, exp_af[r-1]); end
            $display("drain rptr=%0d: wlevel=%0d afull=%b full=%b", r, wlevel, walmost_full, wfull);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] bin = 4'd8;
        logic [3:0] prev_ptr;
        logic [2:0] prev_addr;
        int         addr_wraps = 0;
        int         bin_wraps = 0;
        wr_en = 1'b0; wq2_rptr = g(4'd6);
        tick();
        n_cmp++; if (wlevel !== 4'd2) begin n_bad++; $display("FAIL b2b_prelevel got=%0d exp=2", wlevel); end
        wr_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wq2_rptr = g(bin - 4'd1);
            prev_ptr = wptr;
            prev_addr = waddr;
            #1;
            n_cmp++; if (waddr !== bin[2:0] || wclken !== 1'b1) begin
                n_bad++; $display("FAIL b2b_addr[%0d] got=%0d/%b exp=%0d/1", k, waddr, wclken, bin[2:0]);
            end
            tick();
            bin = bin + 4'd1;
            if (prev_addr == 3'd7 && waddr == 3'd0) addr_wraps++;
            if (bin == 4'd0) bin_wraps++;
            n_cmp++; if (wptr !== g(bin) || $countones(wptr ^ prev_ptr) != 1) begin
                n_bad++; $display("FAIL b2b_wptr[%0d] got=%0d exp=%0d", k, wptr, g(bin));
            end
            n_cmp++; if (wlevel !== 4'd2 || wfull !== 1'b0 || walmost_full !== 1'b0) begin
                n_bad++; $display("FAIL b2b_flags[%0d] got=lvl%0d/full%b/af%b exp=lvl2/full0/af0", k, wlevel, wfull, walmost_full);
            end
            $display("b2b write %0d: waddr=%0d wptr=%0d wlevel=%0d full=%b", k, waddr, wptr, wlevel, wfull);
        end
        n_cmp++; if (addr_wraps < 2 || bin_wraps != 1) begin
            n_bad++; $display("FAIL b2b_wraps got=addr%0d/bin%0d exp=addr>=2/bin1", addr_wraps, bin_wraps);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_mid_reset;
        // wbin is 12 here; one more write against read bin 8 gives level 5.
        wr_en = 1'b1; wq2_rptr = g(4'd8);
        tick();
        n_cmp++; if (wlevel !== 4'd5) begin n_bad++; $display("FAIL midrst_prelevel got=%0d exp=5", wlevel); end
        rst_n = 1'b0; wr_en = 1'b1;
        tick();
        n_cmp++; if ({wptr, wlevel, 1'(waddr != 0), wfull, walmost_full, wovf} !== 12'd0) begin
            n_bad++; $display("FAIL midrst_clear got=wptr%0d/lvl%0d/addr%0d/flags%b exp=all0", wptr, wlevel, waddr, {wfull, walmost_full, wovf});
        end
        $display("mid reset: wptr=%0d wlevel=%0d waddr=%0d", wptr, wlevel, waddr);
        rst_n = 1'b1; wr_en = 1'b0; wq2_rptr = 4'd0;
        tick();
        n_cmp++; if (wptr !== 4'd0 || wlevel !== 4'd0) begin
            n_bad++; $display("FAIL midrst_lost_write got=wptr%0d/lvl%0d exp=0/0", wptr, wlevel);
        end
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (wptr !== 4'd1 || wlevel !== 4'd1) begin
            n_bad++; $display("FAIL midrst_restart got=wptr%0d/lvl%0d exp=1/1", wptr, wlevel);
        end
        $display("post reset write: wptr=%0d wlevel=%0d", wptr, wlevel);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wq2_rptr = 4'd0; ovf_clr = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
